// File: rtl/dma_priority_arbiter_if.sv
// Signal bundle between the DMA channel arbiter and its neighbours (channel
// requests, CPU hold handshake, timing-control strobes, priority readback).
interface dma_priority_arbiter_if;
  // HRQ/HLDA is a level request/acknowledge pair: the arbiter raises HRQ and
  // holds it until it releases the bus; the CPU answers with HLDA and must keep
  // HLDA high until HRQ drops, and the arbiter only leaves RELEASE once HLDA
  // is low again. Dropping HLDA early aborts the grant (holdLost).
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic [3:0] blockMode;
  logic       priorityType;
  logic       HLDA;
  logic       xferDone;
  logic       TC;
  logic       EOP_N;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       startXfer;
  logic       holdLost;
  logic [7:0] priorityOrder;

  modport slave (
    input  DREQ, maskReg, blockMode, priorityType, HLDA, xferDone, TC, EOP_N,
    output HRQ, DACK, activeCh, startXfer, holdLost, priorityOrder
  );

  modport master (
    output DREQ, maskReg, blockMode, priorityType, HLDA, xferDone, TC, EOP_N,
    input  HRQ, DACK, activeCh, startXfer, holdLost, priorityOrder
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 4-channel DMA request arbiter and bus-hold sequencer (fixed or rotating priority).
// Rotating priority is built only when ROTATING_PRIORITY_EN is defined.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  dma_priority_arbiter_if.slave   bus,
  output logic [4:0]              dbg_state
);

  localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    REQ     = 5'b00010,
    GRANT   = 5'b00100,
    XFER    = 5'b01000,
    RELEASE = 5'b10000
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [NUM_CH-1:0] pending;
  logic [1:0]        active_ch;
  logic [1:0]        winner;
  logic              found;
  logic              eop_seen;
  logic              hold_lost;
  logic              xfer_end;
  logic              normal_end;
  logic [7:0]        prio_order;

  assign pending = bus.DREQ & ~bus.maskReg;

  // EOP sampled in the xferDone cycle itself must also end the transfer.
  assign xfer_end = bus.TC | eop_seen | ~bus.EOP_N
                  | bus.maskReg[active_ch] | ~bus.blockMode[active_ch];

  assign normal_end = (state == XFER) && bus.HLDA && bus.xferDone && xfer_end;

  always_comb begin
    winner = prio_order[1:0];
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && pending[prio_order[2*i +: 2]]) begin
        winner = prio_order[2*i +: 2];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|pending) next_state = REQ;
      REQ:     if (bus.HLDA) next_state = (|pending) ? GRANT : RELEASE;
      GRANT:   next_state = bus.HLDA ? XFER : RELEASE;
      XFER: begin
        if (!bus.HLDA)        next_state = RELEASE;
        else if (bus.xferDone) next_state = xfer_end ? RELEASE : GRANT;
      end
      RELEASE: if (!bus.HLDA) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      active_ch <= 2'd0;
      eop_seen  <= 1'b0;
      hold_lost <= 1'b0;
    end else begin
      state     <= next_state;
      hold_lost <= ((state == GRANT) || (state == XFER)) && !bus.HLDA;
      if ((state == REQ) && (next_state == GRANT)) active_ch <= winner;
      if ((next_state == IDLE) && (state != IDLE)) eop_seen <= 1'b0;
      else if ((state == XFER) && !bus.EOP_N)      eop_seen <= 1'b1;
    end
  end

`ifdef ROTATING_PRIORITY_EN
  logic [7:0] rotated;
  int         slot;

  // Serviced channel drops to the lowest slot; the rest close ranks in order.
  always_comb begin
    rotated = DEFAULT_ORDER;
    slot    = 0;
    for (int i = 0; i < 4; i++) begin
      if (prio_order[2*i +: 2] != active_ch) begin
        rotated[2*slot +: 2] = prio_order[2*i +: 2];
        slot = slot + 1;
      end
    end
    rotated[7:6] = active_ch;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)               prio_order <= DEFAULT_ORDER;
    else if (!bus.priorityType) prio_order <= DEFAULT_ORDER;
    else if (normal_end)        prio_order <= rotated;
  end
`else
  logic unused_prio_cfg;
  assign unused_prio_cfg = bus.priorityType | normal_end;
  assign prio_order      = DEFAULT_ORDER;
`endif

  assign bus.HRQ           = (state == REQ) || (state == GRANT) || (state == XFER);
  assign bus.DACK          = ((state == GRANT) || (state == XFER)) ? (4'b0001 << active_ch) : 4'b0000;
  assign bus.activeCh      = active_ch;
  assign bus.startXfer     = (state == GRANT);
  assign bus.holdLost      = hold_lost;
  assign bus.priorityOrder = prio_order;
  assign dbg_state         = state;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus a
// randomized run against a queue-based priority model.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [4:0] dbg_state;

  dma_priority_arbiter_if bus();

  dma_priority_arbiter #(.NUM_CH(4)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

`ifdef ROTATING_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         prio_q[$];
  logic [3:0] exp_q[$];

  // ---------------- reference model: priority list, highest first ----------
  function automatic void model_reset();
    prio_q = {0, 1, 2, 3};
  endfunction

  function automatic logic [7:0] model_order();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 4; i++) v[2*i +: 2] = 2'(prio_q[i]);
    return v;
  endfunction

  function automatic int model_winner(input logic [3:0] pend);
    for (int i = 0; i < 4; i++) if (pend[prio_q[i]]) return prio_q[i];
    return 0;
  endfunction

  function automatic void model_serviced(input int ch, input bit pt);
    if (ROT && pt) begin
      for (int i = 0; i < 4; i++) begin
        if (prio_q[i] == ch) begin
          prio_q.delete(i);
          break;
        end
      end
      prio_q.push_back(ch);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.HRQ === 1'b1) ok = 1'b1;
    end
  endtask

  // HLDA two cycles after HRQ, then the REQ->GRANT edge.
  task automatic grant_bus();
    tick();
    tick();
    bus.HLDA = 1'b1;
    tick();
  endtask

  task automatic done_pulse(input bit tc, input bit eop);
    bus.xferDone = 1'b1;
    bus.TC       = tc;
    bus.EOP_N    = !eop;
    tick();
    bus.xferDone = 1'b0;
    bus.TC       = 1'b0;
    bus.EOP_N    = 1'b1;
  endtask

  task automatic release_bus();
    bus.HLDA = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({bus.HRQ, bus.DACK, bus.activeCh, bus.startXfer, bus.holdLost} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {bus.HRQ, bus.DACK, bus.activeCh, bus.startXfer, bus.holdLost});
    end
    n_checks++;
    if (bus.priorityOrder !== model_order()) begin
      n_fail++;
      $display("FAIL reset_order: got %h want %h", bus.priorityOrder, model_order());
    end
    n_checks++;
    if (dbg_state !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_state: got %b want IDLE", dbg_state);
    end
  endtask

  task automatic test_fixed();
    bit ok;
    bus.priorityType = 1'b0;
    bus.maskReg      = 4'b0000;
    bus.blockMode    = 4'b0000;
    bus.DREQ         = 4'b1110;
    wait_hrq(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL fixed_hrq: got timeout want HRQ=1"); end
    grant_bus();
    n_checks++;
    if (bus.DACK !== 4'b0010 || bus.startXfer !== 1'b1) begin
      n_fail++;
      $display("FAIL fixed_dack_1110: got dack=%b start=%b want 0010/1", bus.DACK, bus.startXfer);
    end
    tick();
    done_pulse(1'b0, 1'b0);
    n_checks++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) begin
      n_fail++;
      $display("FAIL fixed_end: got hrq=%b dack=%b want 0/0000", bus.HRQ, bus.DACK);
    end
    bus.DREQ = 4'b1111;
    release_bus();
    wait_hrq(ok);
    grant_bus();
    n_checks++;
    if (bus.DACK !== 4'b0001 || bus.activeCh !== 2'd0) begin
      n_fail++;
      $display("FAIL fixed_dack_1111: got dack=%b ch=%0d want 0001/0", bus.DACK, bus.activeCh);
    end
    tick();
    bus.DREQ = 4'b0000;
    done_pulse(1'b0, 1'b0);
    release_bus();
  endtask

  task automatic test_rotating();
    bit ok;
    int win;
    bus.priorityType = 1'b1;
    bus.DREQ         = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      win = model_winner(4'b1111);
      wait_hrq(ok);
      grant_bus();
      n_checks++;
      if (bus.DACK !== (4'b0001 << win)) begin
        n_fail++;
        $display("FAIL rot_dack_%0d: got %b want %b", r, bus.DACK, 4'b0001 << win);
      end
      tick();
      done_pulse(1'b0, 1'b0);
      model_serviced(win, 1'b1);
      n_checks++;
      if (bus.priorityOrder !== model_order()) begin
        n_fail++;
        $display("FAIL rot_order_%0d: got %b want %b", r, bus.priorityOrder, model_order());
      end
      if (r == 1) bus.DREQ = 4'b0000;
      release_bus();
    end
    bus.priorityType = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (bus.priorityOrder !== model_order()) begin
      n_fail++;
      $display("FAIL rot_reload: got %b want %b", bus.priorityOrder, model_order());
    end
  endtask

  task automatic test_block();
    bit ok;
    int starts;
    bus.DREQ      = 4'b0100;
    bus.blockMode = 4'b0100;
    starts        = 0;
    wait_hrq(ok);
    grant_bus();
    for (int w = 0; w < 3; w++) begin
      if (bus.startXfer === 1'b1) starts++;
      n_checks++;
      if (bus.DACK !== 4'b0100) begin
        n_fail++;
        $display("FAIL block_dack_grant_%0d: got %b want 0100", w, bus.DACK);
      end
      tick();
      n_checks++;
      if (bus.DACK !== 4'b0100 || bus.startXfer !== 1'b0) begin
        n_fail++;
        $display("FAIL block_dack_xfer_%0d: got dack=%b start=%b want 0100/0", w, bus.DACK, bus.startXfer);
      end
      done_pulse(w == 2, 1'b0);
    end
    n_checks++;
    if (starts !== 3) begin n_fail++; $display("FAIL block_starts: got %0d want 3", starts); end
    n_checks++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) begin
      n_fail++;
      $display("FAIL block_end: got hrq=%b dack=%b want 0/0000", bus.HRQ, bus.DACK);
    end
    release_bus();
    // masking the active block channel ends after the current word
    wait_hrq(ok);
    grant_bus();
    tick();
    bus.maskReg = 4'b0100;
    done_pulse(1'b0, 1'b0);
    n_checks++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) begin
      n_fail++;
      $display("FAIL block_mask_end: got hrq=%b dack=%b want 0/0000", bus.HRQ, bus.DACK);
    end
    bus.DREQ      = 4'b0000;
    bus.maskReg   = 4'b0000;
    bus.blockMode = 4'b0000;
    release_bus();
  endtask

  task automatic test_hold_lost();
    bit ok;
    bus.priorityType = ROT;
    bus.DREQ         = 4'b0001;
    wait_hrq(ok);
    grant_bus();
    bus.DREQ = 4'b0000;
    tick();
    bus.HLDA = 1'b0;
    tick();
    n_checks++;
    if (bus.holdLost !== 1'b1 || bus.DACK !== 4'b0000 || bus.HRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_lost: got lost=%b dack=%b hrq=%b want 1/0000/0", bus.holdLost, bus.DACK, bus.HRQ);
    end
    n_checks++;
    if (bus.priorityOrder !== model_order()) begin
      n_fail++;
      $display("FAIL hold_lost_order: got %b want %b", bus.priorityOrder, model_order());
    end
    tick();
    n_checks++;
    if (bus.holdLost !== 1'b0) begin n_fail++; $display("FAIL hold_lost_pulse: got %b want 0", bus.holdLost); end
  endtask

  task automatic test_mask();
    int hrq_seen;
    bus.DREQ    = 4'b0001;
    bus.maskReg = 4'b0001;
    hrq_seen    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.HRQ !== 1'b0) hrq_seen++;
    end
    n_checks++;
    if (hrq_seen !== 0) begin n_fail++; $display("FAIL mask_hold: got %0d HRQ cycles want 0", hrq_seen); end
    bus.maskReg = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (bus.HRQ !== 1'b1) begin n_fail++; $display("FAIL mask_clear: got hrq=%b want 1", bus.HRQ); end
    // request withdrawn before HLDA: REQ goes straight to RELEASE
    bus.DREQ = 4'b0000;
    bus.HLDA = 1'b1;
    tick();
    n_checks++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) begin
      n_fail++;
      $display("FAIL req_no_pending: got hrq=%b dack=%b want 0/0000", bus.HRQ, bus.DACK);
    end
    release_bus();
  endtask

  task automatic test_random();
    bit         ok;
    bit         pt;
    bit         blk;
    bit         ends;
    int         win;
    int         eop_at;
    int         wait_cyc;
    int         eop_cyc;
    int         w;
    logic [3:0] exp_dack;
    for (int it = 0; it < 40; it++) begin
      pt = 1'($urandom_range(0, 1));
      bus.priorityType = pt;
      if (!pt) model_reset();
      do begin
        bus.DREQ    = 4'($urandom_range(1, 15));
        bus.maskReg = 4'($urandom_range(0, 15));
      end while ((bus.DREQ & ~bus.maskReg) == 4'b0000);
      bus.blockMode = 4'($urandom_range(0, 15));
      win    = model_winner(bus.DREQ & ~bus.maskReg);
      blk    = bus.blockMode[win];
      eop_at = blk ? $urandom_range(0, 3) : 3;
      exp_q.push_back(4'b0001 << win);
      wait_hrq(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rnd_hrq_%0d: got timeout want HRQ=1", it); end
      grant_bus();
      exp_dack = exp_q.pop_front();
      n_checks++;
      if (bus.DACK !== exp_dack || bus.startXfer !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_grant_%0d: got dack=%b start=%b want %b/1", it, bus.DACK, bus.startXfer, exp_dack);
      end
      ends = 1'b0;
      w    = 0;
      while (!ends) begin
        wait_cyc = $urandom_range(0, 2);
        eop_cyc  = $urandom_range(0, wait_cyc);
        tick();
        for (int j = 0; j <= wait_cyc; j++) begin
          bus.DREQ     = 4'($urandom_range(0, 15));
          bus.EOP_N    = !((w == eop_at) && (j == eop_cyc));
          bus.xferDone = (j == wait_cyc);
          bus.TC       = (j == wait_cyc) && (blk ? (w == 2) : 1'($urandom_range(0, 1)));
          tick();
        end
        bus.xferDone = 1'b0;
        bus.TC       = 1'b0;
        bus.EOP_N    = 1'b1;
        ends = !blk || (w == 2) || (w == eop_at);
        if (ends) begin
          model_serviced(win, pt);
          n_checks++;
          if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000 || bus.priorityOrder !== model_order()) begin
            n_fail++;
            $display("FAIL rnd_end_%0d: got hrq=%b dack=%b order=%b want 0/0000/%b",
                     it, bus.HRQ, bus.DACK, bus.priorityOrder, model_order());
          end
        end else begin
          n_checks++;
          if (bus.startXfer !== 1'b1 || bus.DACK !== exp_dack || bus.activeCh !== 2'(win)) begin
            n_fail++;
            $display("FAIL rnd_cont_%0d_%0d: got start=%b dack=%b ch=%0d want 1/%b/%0d",
                     it, w, bus.startXfer, bus.DACK, bus.activeCh, exp_dack, win);
          end
        end
        w++;
      end
      release_bus();
    end
    bus.DREQ = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_xfer();
    bit ok;
    bus.maskReg   = 4'b0000;
    bus.blockMode = 4'b0010;
    bus.DREQ      = 4'b0010;
    wait_hrq(ok);
    grant_bus();
    tick();
    #3;
    RESET_N = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000 || bus.priorityOrder !== model_order()) begin
      n_fail++;
      $display("FAIL reset_async: got hrq=%b dack=%b order=%h want 0/0000/%h",
               bus.HRQ, bus.DACK, bus.priorityOrder, model_order());
    end
    bus.DREQ = 4'b0000;
    bus.HLDA = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    n_checks++;
    if (dbg_state !== 5'b00001 || bus.HRQ !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got state=%b hrq=%b want IDLE/0", dbg_state, bus.HRQ);
    end
  endtask

  initial begin
    bus.DREQ         = 4'b0000;
    bus.maskReg      = 4'b0000;
    bus.blockMode    = 4'b0000;
    bus.priorityType = 1'b0;
    bus.HLDA         = 1'b0;
    bus.xferDone     = 1'b0;
    bus.TC           = 1'b0;
    bus.EOP_N        = 1'b1;
    model_reset();
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
    test_reset();
    test_fixed();
    test_rotating();
    test_block();
    test_hold_lost();
    test_mask();
    test_random();
    test_reset_mid_xfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
